// File: rtl/present_core_nibble_pkg.sv
// Shared definitions for the PRESENT-80 nibble-serial engine:
// round count, FSM encoding and the 4-bit S-box table.
package present_core_nibble_pkg;

    localparam int PRESENT_ROUNDS = 31;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDKEY = 3'd1,
        ST_SBOX   = 3'd2,
        ST_PERM   = 3'd3,
        ST_FINAL  = 3'd4,
        ST_DONE   = 3'd5
    } fsm_state_t;

    function automatic logic [3:0] sbox_lookup(input logic [3:0] x);
        logic [3:0] y;
        y = 4'h0;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/present_core_nibble_sbox.sv
// Combinational 4-bit PRESENT S-box; instantiated once for the state
// datapath and once for the key schedule.
module present_sbox
    import present_core_nibble_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = sbox_lookup(din);

endmodule

// File: rtl/present_core_nibble.sv
// PRESENT-80 encryption engine: one S-box substitution per cycle on a rotating
// 64-bit state, 18 cycles per round, registered ready status.
module present_core_nibble
    import present_core_nibble_pkg::*;
#(
    parameter int NUM_ROUNDS = PRESENT_ROUNDS
) (
    input  logic        Clk_ik,
    input  logic        Reset_ir,
    input  logic [63:0] PlainText_ib,
    input  logic [79:0] Key_ib,
    input  logic        Start_i,
    output logic [63:0] CipherText_ob,
    output logic        Ready_o
);

    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

    fsm_state_t  fsm_q;
    logic [63:0] state_q;
    logic [79:0] key_q;
    logic [4:0]  round_q;
    logic [3:0]  nibble_q;
    logic        ready_q;

    logic [3:0]  state_sbox_out;
    logic [79:0] key_rot;
    logic [3:0]  key_sbox_out;
    logic [79:0] key_next;
    logic [63:0] perm_state;

    present_sbox u_state_sbox (
        .din  (state_q[3:0]),
        .dout (state_sbox_out)
    );

    // Key schedule: rotate left by 61, substitute the top nibble, mix in the round number.
    assign key_rot = {key_q[18:0], key_q[79:19]};

    present_sbox u_key_sbox (
        .din  (key_rot[79:76]),
        .dout (key_sbox_out)
    );

    assign key_next = {key_sbox_out, key_rot[75:20], key_rot[19:15] ^ round_q, key_rot[14:0]};

    for (genvar i = 0; i < 63; i++) begin : g_perm
        assign perm_state[(16 * i) % 63] = state_q[i];
    end
    assign perm_state[63] = state_q[63];

    // NOTE: all state is updated with non-blocking assignments so every branch
    // below sees the pre-edge values of state_q, key_q and round_q.
    always_ff @(posedge Clk_ik or posedge Reset_ir) begin
        if (Reset_ir) begin
            fsm_q    <= ST_IDLE;
            state_q  <= '0;
            key_q    <= '0;
            round_q  <= 5'd1;
            nibble_q <= '0;
            ready_q  <= 1'b1;
        end else begin
            case (fsm_q)
                ST_IDLE, ST_DONE: begin
                    if (Start_i) begin
                        state_q <= PlainText_ib;
                        key_q   <= Key_ib;
                        round_q <= 5'd1;
                        ready_q <= 1'b0;
                        fsm_q   <= ST_ADDKEY;
                    end
                end
                ST_ADDKEY: begin
                    state_q  <= state_q ^ key_q[79:16];
                    nibble_q <= '0;
                    fsm_q    <= ST_SBOX;
                end
                ST_SBOX: begin
                    // Substituted nibble re-enters at the top; after 16 shifts all are back in place.
                    state_q  <= {state_sbox_out, state_q[63:4]};
                    nibble_q <= nibble_q + 4'd1;
                    if (nibble_q == 4'd15)
                        fsm_q <= ST_PERM;
                end
                ST_PERM: begin
                    state_q <= perm_state;
                    key_q   <= key_next;
                    if (round_q < LAST_ROUND) begin
                        round_q <= round_q + 5'd1;
                        fsm_q   <= ST_ADDKEY;
                    end else begin
                        fsm_q <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    state_q <= state_q ^ key_q[79:16];
                    ready_q <= 1'b1;
                    fsm_q   <= ST_DONE;
                end
                default: begin
                    fsm_q   <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign CipherText_ob = state_q;
    assign Ready_o       = ready_q;

endmodule

// File: tb/tb_present_core_nibble.sv
// Self-checking bench for present_core_nibble: known-answer vectors, random
// vectors against a round-level PRESENT-80 model, and control-path scenarios.
module tb_present_core_nibble;

    localparam int LATENCY = 559;
    localparam int BUDGET  = 2000;
    localparam logic [63:0] CT_ZERO = 64'h5579C1387B228445;

    localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    logic        Clk_ik = 1'b0;
    logic        Reset_ir = 1'b1;
    logic [63:0] PlainText_ib = '0;
    logic [79:0] Key_ib = '0;
    logic        Start_i = 1'b0;
    logic [63:0] CipherText_ob;
    logic        Ready_o;

    int n_pass = 0;
    int n_total = 0;

    present_core_nibble dut (
        .Clk_ik        (Clk_ik),
        .Reset_ir      (Reset_ir),
        .PlainText_ib  (PlainText_ib),
        .Key_ib        (Key_ib),
        .Start_i       (Start_i),
        .CipherText_ob (CipherText_ob),
        .Ready_o       (Ready_o)
    );

    always #5 Clk_ik = ~Clk_ik;

    // Reference PRESENT-80 encryption: whole-round operations on plain vectors.
    function automatic logic [63:0] present_ref(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] s, p;
        logic [79:0] k;
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++)
                s[4*n +: 4] = SB[s[4*n +: 4]];
            p = '0;
            for (int b = 0; b < 64; b++)
                p[(b == 63) ? 63 : (b * 16) % 63] = s[b];
            s = p;
            k = {k[18:0], k[79:19]};
            k[79:76] = SB[k[79:76]];
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    task automatic do_reset();
        Reset_ir = 1'b1;
        Start_i  = 1'b0;
        repeat (2) @(posedge Clk_ik);
        #1 Reset_ir = 1'b0;
    endtask

    // Pulse start, optionally scramble inputs after acceptance or re-pulse start,
    // and count edges after the accepting edge until Ready_o rises.
    task automatic run_enc(input logic [63:0] pt, input logic [79:0] key, input bit scramble,
                           input int repulse_at, output logic [63:0] ct, output int edges,
                           output bit busy_seen);
        PlainText_ib = pt;
        Key_ib       = key;
        Start_i      = 1'b1;
        @(posedge Clk_ik);
        #1;
        Start_i   = 1'b0;
        busy_seen = (Ready_o === 1'b0);
        if (scramble) begin
            PlainText_ib = {$urandom, $urandom};
            Key_ib       = {16'($urandom), $urandom, $urandom};
        end
        edges = 0;
        while (edges < BUDGET) begin
            Start_i = (edges + 1 == repulse_at);
            @(posedge Clk_ik);
            #1;
            edges++;
            if (Ready_o === 1'b1) break;
        end
        Start_i = 1'b0;
        ct = CipherText_ob;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (Ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", Ready_o);
        else n_pass++;
        n_total++;
        if (CipherText_ob !== 64'h0) $display("FAIL reset_ct: got %h want 0", CipherText_ob);
        else n_pass++;
    endtask

    task automatic test_known_answers();
        logic [63:0] pts [4] = '{64'h0, 64'h0, '1, '1};
        logic [79:0] keys [4] = '{80'h0, '1, 80'h0, '1};
        logic [63:0] exp [4] = '{CT_ZERO, 64'hE72C46C0F5945049, 64'hA112FFC72F68417B, 64'h3333DCD3213210D2};
        logic [63:0] ct;
        int edges;
        bit busy;
        for (int v = 0; v < 4; v++) begin
            run_enc(pts[v], keys[v], v == 3, 0, ct, edges, busy);
            n_total++;
            if (!busy) $display("FAIL kat%0d_busy: Ready_o still high after start", v);
            else n_pass++;
            n_total++;
            if (edges != LATENCY) $display("FAIL kat%0d_latency: got %0d edges want %0d", v, edges, LATENCY);
            else n_pass++;
            n_total++;
            if (ct !== exp[v]) $display("FAIL kat%0d_ct: got %h want %h", v, ct, exp[v]);
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        logic [63:0] held;
        held = CipherText_ob;
        repeat (20) @(posedge Clk_ik);
        #1;
        n_total++;
        if (CipherText_ob !== held || Ready_o !== 1'b1)
            $display("FAIL idle_hold: got ct=%h ready=%b want ct=%h ready=1", CipherText_ob, Ready_o, held);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [63:0] pt, ct, exp;
        logic [79:0] key;
        int edges;
        bit busy;
        for (int v = 0; v < 6; v++) begin
            pt  = {$urandom, $urandom};
            key = {16'($urandom), $urandom, $urandom};
            exp = present_ref(pt, key);
            run_enc(pt, key, 1'b1, 0, ct, edges, busy);
            n_total++;
            if (edges != LATENCY || ct !== exp)
                $display("FAIL rand%0d: got ct=%h edges=%0d want ct=%h edges=%0d", v, ct, edges, exp, LATENCY);
            else n_pass++;
        end
    endtask

    task automatic test_busy_restart();
        logic [63:0] ct;
        int edges;
        bit busy;
        run_enc(64'h0, 80'h0, 1'b0, 100, ct, edges, busy);
        n_total++;
        if (edges != LATENCY) $display("FAIL repulse_latency: got %0d edges want %0d", edges, LATENCY);
        else n_pass++;
        n_total++;
        if (ct !== CT_ZERO) $display("FAIL repulse_ct: got %h want %h", ct, CT_ZERO);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] ct;
        int edges;
        bit busy;
        PlainText_ib = '0;
        Key_ib       = '0;
        Start_i      = 1'b1;
        @(posedge Clk_ik);
        #1 Start_i = 1'b0;
        repeat (300) @(posedge Clk_ik);
        #2;
        n_total++;
        if (Ready_o !== 1'b0) $display("FAIL midrun_busy: got ready=%b want 0", Ready_o);
        else n_pass++;
        Reset_ir = 1'b1;
        #1;
        n_total++;
        if (Ready_o !== 1'b1 || CipherText_ob !== 64'h0)
            $display("FAIL midrun_reset: got ready=%b ct=%h want ready=1 ct=0", Ready_o, CipherText_ob);
        else n_pass++;
        @(posedge Clk_ik);
        #1 Reset_ir = 1'b0;
        run_enc(64'h0, 80'h0, 1'b0, 0, ct, edges, busy);
        n_total++;
        if (edges != LATENCY || ct !== CT_ZERO)
            $display("FAIL post_reset_run: got ct=%h edges=%0d want ct=%h edges=%0d", ct, edges, CT_ZERO, LATENCY);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int edges;
        PlainText_ib = '0;
        Key_ib       = '0;
        Start_i      = 1'b1;
        @(posedge Clk_ik);
        #1;
        edges = 0;
        while (edges < BUDGET) begin
            @(posedge Clk_ik);
            #1;
            edges++;
            if (Ready_o === 1'b1) break;
        end
        n_total++;
        if (edges != LATENCY || CipherText_ob !== CT_ZERO)
            $display("FAIL b2b_first: got ct=%h edges=%0d want ct=%h edges=%0d", CipherText_ob, edges, CT_ZERO, LATENCY);
        else n_pass++;
        @(posedge Clk_ik);
        #1;
        Start_i = 1'b0;
        n_total++;
        if (Ready_o !== 1'b0) $display("FAIL b2b_restart: got ready=%b want 0 one cycle after done", Ready_o);
        else n_pass++;
        edges = 0;
        while (edges < BUDGET) begin
            @(posedge Clk_ik);
            #1;
            edges++;
            if (Ready_o === 1'b1) break;
        end
        n_total++;
        if (edges != LATENCY || CipherText_ob !== CT_ZERO)
            $display("FAIL b2b_second: got ct=%h edges=%0d want ct=%h edges=%0d", CipherText_ob, edges, CT_ZERO, LATENCY);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_known_answers();
        test_hold();
        test_random();
        test_busy_restart();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
